// File: rtl/alu_seq_pkg.sv
// Shared types and decode for the sequential ALU: op classes, operation enum, FSM states.
// The M-extension decode is present only when ALU_SEQ_MDEXT_EN is defined.
package alu_seq_pkg;

  localparam logic [1:0] OP_ADD    = 2'b00;
  localparam logic [1:0] OP_BRANCH = 2'b01;
  localparam logic [1:0] OP_RTYPE  = 2'b10;
  localparam logic [1:0] OP_ITYPE  = 2'b11;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  typedef enum logic [4:0] {
    FN_ADD, FN_SUB, FN_SLL, FN_SLT, FN_SLTU, FN_XOR, FN_SRL, FN_SRA, FN_OR, FN_AND,
    FN_BEQ, FN_BNE, FN_BLT, FN_BGE, FN_BLTU, FN_BGEU,
    FN_MUL, FN_MULH, FN_MULHSU, FN_MULHU, FN_DIV, FN_DIVU, FN_REM, FN_REMU,
    FN_ILLEGAL
  } alu_fn_t;

  function automatic alu_fn_t decode_fn(input logic [1:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7);
    alu_fn_t fn;
    fn = FN_ILLEGAL;
    case (op)
      OP_ADD: fn = FN_ADD;
      OP_BRANCH: begin
        case (f3)
          3'b000:  fn = FN_BEQ;
          3'b001:  fn = FN_BNE;
          3'b100:  fn = FN_BLT;
          3'b101:  fn = FN_BGE;
          3'b110:  fn = FN_BLTU;
          3'b111:  fn = FN_BGEU;
          default: fn = FN_ILLEGAL;
        endcase
      end
      OP_RTYPE: begin
        if (f7 == F7_BASE) begin
          case (f3)
            3'b000:  fn = FN_ADD;
            3'b001:  fn = FN_SLL;
            3'b010:  fn = FN_SLT;
            3'b011:  fn = FN_SLTU;
            3'b100:  fn = FN_XOR;
            3'b101:  fn = FN_SRL;
            3'b110:  fn = FN_OR;
            default: fn = FN_AND;
          endcase
        end else if (f7 == F7_ALT) begin
          if (f3 == 3'b000) fn = FN_SUB;
          else if (f3 == 3'b101) fn = FN_SRA;
        end
`ifdef ALU_SEQ_MDEXT_EN
        else if (f7 == F7_MULDIV) begin
          case (f3)
            3'b000:  fn = FN_MUL;
            3'b001:  fn = FN_MULH;
            3'b010:  fn = FN_MULHSU;
            3'b011:  fn = FN_MULHU;
            3'b100:  fn = FN_DIV;
            3'b101:  fn = FN_DIVU;
            3'b110:  fn = FN_REM;
            default: fn = FN_REMU;
          endcase
        end
`endif
      end
      default: begin
        case (f3)
          3'b000:  fn = FN_ADD;
          3'b001:  fn = (f7 == F7_BASE) ? FN_SLL : FN_ILLEGAL;
          3'b010:  fn = FN_SLT;
          3'b011:  fn = FN_SLTU;
          3'b100:  fn = FN_XOR;
          3'b101:  fn = (f7 == F7_BASE) ? FN_SRL : (f7 == F7_ALT) ? FN_SRA : FN_ILLEGAL;
          3'b110:  fn = FN_OR;
          default: fn = FN_AND;
        endcase
      end
    endcase
    return fn;
  endfunction

  function automatic logic fn_is_muldiv(input alu_fn_t fn);
    return fn inside {FN_MUL, FN_MULH, FN_MULHSU, FN_MULHU, FN_DIV, FN_DIVU, FN_REM, FN_REMU};
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply/divide: shift-add multiplier and restoring divider on magnitudes,
// one bit per cycle, with sign fix-up on the held result. Used only with ALU_SEQ_MDEXT_EN.
module alu_muldiv_iter
  import alu_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  alu_fn_t         fn_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  localparam int CW = $clog2(XLEN) + 1;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic              done_q, done_d;
  alu_fn_t           fn_q, fn_d;
  logic              is_div_q, is_div_d;
  logic              qneg_q, qneg_d, rneg_q, rneg_d;
  logic [2*XLEN-1:0] p_q, p_d;
  logic [XLEN-1:0]   m_q, m_d;

  logic              is_div, sa, sb;
  logic [XLEN-1:0]   a_mag, b_mag, quo, rem;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] p_mul, p_div, prod_fix;

  always_comb begin
    is_div = fn_i inside {FN_DIV, FN_DIVU, FN_REM, FN_REMU};
    sa     = (fn_i inside {FN_MULH, FN_MULHSU, FN_DIV, FN_REM}) && a_i[XLEN-1];
    sb     = (fn_i inside {FN_MULH, FN_DIV, FN_REM}) && b_i[XLEN-1];
    a_mag  = sa ? -a_i : a_i;
    b_mag  = sb ? -b_i : b_i;
  end

  // p holds {accumulator, multiplier} for multiply, {partial remainder, dividend->quotient} for divide
  always_comb begin
    mul_sum   = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, m_q} : '0);
    p_mul     = {mul_sum, p_q[XLEN-1:1]};
    div_shift = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, m_q};
    p_div     = div_diff[XLEN] ? {div_shift[XLEN-1:0], p_q[XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0], p_q[XLEN-2:0], 1'b1};
  end

  always_comb begin
    cnt_d    = cnt_q;
    done_d   = done_q;
    fn_d     = fn_q;
    is_div_d = is_div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    p_d      = p_q;
    m_d      = m_q;
    if (start_i) begin
      cnt_d    = CW'(XLEN);
      done_d   = 1'b0;
      fn_d     = fn_i;
      is_div_d = is_div;
      qneg_d   = sa ^ sb;
      rneg_d   = sa;
      p_d      = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
      m_d      = is_div ? b_mag : a_mag;
    end else if (cnt_q != '0) begin
      p_d    = is_div_q ? p_div : p_mul;
      cnt_d  = cnt_q - CW'(1);
      done_d = (cnt_q == CW'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      done_q   <= 1'b0;
      fn_q     <= FN_ILLEGAL;
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      p_q      <= '0;
      m_q      <= '0;
    end else begin
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      fn_q     <= fn_d;
      is_div_q <= is_div_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      p_q      <= p_d;
      m_q      <= m_d;
    end
  end

  always_comb begin
    prod_fix = qneg_q ? -p_q : p_q;
    quo      = qneg_q ? -p_q[XLEN-1:0] : p_q[XLEN-1:0];
    rem      = rneg_q ? -p_q[2*XLEN-1:XLEN] : p_q[2*XLEN-1:XLEN];
    case (fn_q)
      FN_MUL:                       result_o = prod_fix[XLEN-1:0];
      FN_MULH, FN_MULHSU, FN_MULHU: result_o = prod_fix[2*XLEN-1:XLEN];
      FN_DIV, FN_DIVU:              result_o = quo;
      FN_REM, FN_REMU:              result_o = rem;
      default:                      result_o = '0;
    endcase
  end

  assign done_o = done_q;

endmodule

// File: rtl/alu_seq_unit.sv
// Sequential RV-style ALU with valid/ready handshakes; single-cycle ops go IDLE->DONE.
// Define ALU_SEQ_MDEXT_EN to add the iterative M extension (IDLE->CALC->DONE).
module alu_seq_unit
  import alu_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal,
  output logic            busy
);
  localparam int SHW = $clog2(XLEN);

  state_t          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            illegal_q, illegal_d;
  logic            live_q;

  alu_fn_t         fn;
  logic            accept, iter_start, md_done;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res, md_result;

  assign fn     = decode_fn(alu_op, funct3, funct7);
  assign accept = in_valid && in_ready;
  assign shamt  = op_b[SHW-1:0];

`ifdef ALU_SEQ_MDEXT_EN
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  logic b_zero, ovf, md_fast;
  // Divide-by-zero and signed overflow have fixed answers and bypass the iterator
  assign b_zero     = (op_b == '0);
  assign ovf        = (op_a == MIN_NEG) && (op_b == '1);
  assign md_fast    = ((fn inside {FN_DIV, FN_DIVU, FN_REM, FN_REMU}) && b_zero) ||
                      ((fn inside {FN_DIV, FN_REM}) && ovf);
  assign iter_start = accept && fn_is_muldiv(fn) && !md_fast;

  alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (iter_start),
    .fn_i     (fn),
    .a_i      (op_a),
    .b_i      (op_b),
    .done_o   (md_done),
    .result_o (md_result)
  );
`else
  assign iter_start = 1'b0;
  assign md_done    = 1'b0;
  assign md_result  = '0;
`endif

  always_comb begin
    alu_res = '0;
    case (fn)
      FN_ADD:  alu_res = op_a + op_b;
      FN_SUB:  alu_res = op_a - op_b;
      FN_SLL:  alu_res = op_a << shamt;
      FN_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      FN_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      FN_XOR:  alu_res = op_a ^ op_b;
      FN_SRL:  alu_res = op_a >> shamt;
      FN_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
      FN_OR:   alu_res = op_a | op_b;
      FN_AND:  alu_res = op_a & op_b;
      FN_BEQ:  alu_res = {{(XLEN-1){1'b0}}, (op_a == op_b)};
      FN_BNE:  alu_res = {{(XLEN-1){1'b0}}, (op_a != op_b)};
      FN_BLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      FN_BGE:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) >= $signed(op_b))};
      FN_BLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      FN_BGEU: alu_res = {{(XLEN-1){1'b0}}, (op_a >= op_b)};
`ifdef ALU_SEQ_MDEXT_EN
      FN_DIV, FN_DIVU: alu_res = b_zero ? '1 : op_a;
      FN_REM, FN_REMU: alu_res = b_zero ? op_a : '0;
`endif
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      result_q  <= '0;
      illegal_q <= 1'b0;
      live_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
      live_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    case (state_q)
      S_CALC: begin
        if (md_done) begin
          state_d   = S_DONE;
          result_d  = md_result;
          illegal_d = 1'b0;
        end
      end
      S_DONE: begin
        if (!accept && out_ready) state_d = S_IDLE;
      end
      default: ;
    endcase
    if (accept) begin
      state_d   = iter_start ? S_CALC : S_DONE;
      result_d  = alu_res;
      illegal_d = (fn == FN_ILLEGAL);
    end
  end

  always_comb begin
    in_ready  = live_q && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
    out_valid = (state_q == S_DONE);
`ifdef ALU_SEQ_MDEXT_EN
    busy      = (state_q == S_CALC);
`else
    busy      = 1'b0;
`endif
    result    = result_q;
    illegal   = illegal_q;
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Scoreboard bench for alu_seq_unit: a driver pushes reference-model results on acceptance,
// a monitor pops and compares on every presented result (latency, value, illegal).
module tb_alu_seq_unit;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [1:0]      alu_op = '0;
  logic [6:0]      funct7 = '0;
  logic [2:0]      funct3 = '0;
  logic [XLEN-1:0] op_a = '0, op_b = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] result;
  logic            illegal;
  logic            busy;

  alu_seq_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct7(funct7), .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .illegal(illegal),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 0;
  bit   head_seen = 0;
  bit   rand_rdy = 0;
  logic rdy_lvl = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

`ifdef ALU_SEQ_MDEXT_EN
  function automatic void md_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 inout exp_t e);
    int sa, sb;
    longint p;
    longint unsigned pu;
    sa = a;
    sb = b;
    e.lat = XLEN + 1;
    case (f3)
      3'd0: begin p = longint'(sa) * longint'(sb); e.res = p[31:0]; end
      3'd1: begin p = longint'(sa) * longint'(sb); e.res = p[63:32]; end
      3'd2: begin p = longint'(sa) * longint'({32'h0, b}); e.res = p[63:32]; end
      3'd3: begin pu = {32'h0, a} * {32'h0, b}; e.res = pu[63:32]; end
      default: begin
        if (b == 32'h0) begin
          e.lat = 1;
          e.res = (f3 == 3'd4 || f3 == 3'd5) ? 32'hFFFF_FFFF : a;
        end else if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.lat = 1;
          e.res = (f3 == 3'd4) ? a : 32'h0;
        end else begin
          case (f3)
            3'd4:    e.res = sa / sb;
            3'd5:    e.res = a / b;
            3'd6:    e.res = sa % sb;
            default: e.res = a % b;
          endcase
        end
      end
    endcase
  endfunction
`endif

  function automatic exp_t model(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int sa, sb;
    int unsigned sh;
    e.res = 0; e.ill = 0; e.lat = 1; e.acc = 0;
    sa = a; sb = b; sh = b % 32;
    case (op)
      2'd0: e.res = a + b;
      2'd1: case (f3)
          3'd0: e.res = 32'(a == b);
          3'd1: e.res = 32'(a != b);
          3'd4: e.res = 32'(sa < sb);
          3'd5: e.res = 32'(sa >= sb);
          3'd6: e.res = 32'(a < b);
          3'd7: e.res = 32'(a >= b);
          default: e.ill = 1;
        endcase
      2'd2: begin
        if (f7 == 7'h00) case (f3)
            3'd0: e.res = a + b;
            3'd1: e.res = a << sh;
            3'd2: e.res = 32'(sa < sb);
            3'd3: e.res = 32'(a < b);
            3'd4: e.res = a ^ b;
            3'd5: e.res = a >> sh;
            3'd6: e.res = a | b;
            default: e.res = a & b;
          endcase
        else if (f7 == 7'h20 && f3 == 3'd0) e.res = a - b;
        else if (f7 == 7'h20 && f3 == 3'd5) e.res = sa >>> sh;
`ifdef ALU_SEQ_MDEXT_EN
        else if (f7 == 7'h01) md_ref(f3, a, b, e);
`endif
        else e.ill = 1;
      end
      default: case (f3)
          3'd0: e.res = a + b;
          3'd1: if (f7 == 7'h00) e.res = a << sh; else e.ill = 1;
          3'd2: e.res = 32'(sa < sb);
          3'd3: e.res = 32'(a < b);
          3'd4: e.res = a ^ b;
          3'd5: if (f7 == 7'h00) e.res = a >> sh;
                else if (f7 == 7'h20) e.res = sa >>> sh;
                else e.ill = 1;
          3'd6: e.res = a | b;
          default: e.res = a & b;
        endcase
    endcase
    if (e.ill) e.res = 0;
    return e;
  endfunction

  always @(posedge clk) begin
    #2;
    out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_lvl;
  end

  always @(negedge clk) begin
    if (mon_en && rst_n && out_valid) begin
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_out: result %0h presented, no result expected", result);
      end else begin
        if (!head_seen) begin
          chk("latency", 64'(cyc - sbq[0].acc), 64'(sbq[0].lat));
          head_seen = 1;
        end
        chk("result", result, sbq[0].res);
        chk("illegal", illegal, sbq[0].ill);
        if (out_ready) begin
          void'(sbq.pop_front());
          head_seen = 0;
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int w = 0;
    alu_op = op; funct3 = f3; funct7 = f7; op_a = a; op_b = b; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && w < 200) begin w++; @(negedge clk); end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, expected 1", in_ready, w);
    end else begin
      e = model(op, f3, f7, a, b);
      e.acc = cyc;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sbq.size() != 0 && w < 1000) begin w++; @(negedge clk); end
    if (sbq.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d results pending, expected 0", sbq.size());
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [6:0] f7;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_result", result, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_pre_edge", in_ready, 0);
    @(negedge clk);
    chk("in_ready_post_edge", in_ready, 1);
    mon_en = 1;
    @(posedge clk); #1;

    issue(2'b10, 3'b000, 7'h20, 32'd5, 32'd7);
    issue(2'b11, 3'b101, 7'h20, 32'h8000_0000, 32'h24);
    issue(2'b10, 3'b001, 7'h20, 32'd3, 32'd4);
    issue(2'b10, 3'b000, 7'h01, 32'd6, 32'd7);
`ifndef ALU_SEQ_MDEXT_EN
    chk("busy_tied_low", busy, 0);
`endif
    issue(2'b00, 3'b111, 7'h7F, 32'hFFFF_FFFF, 32'd2);
    issue(2'b11, 3'b001, 7'h20, 32'd1, 32'd1);
    issue(2'b01, 3'b010, 7'h00, 32'd1, 32'd1);
    drain();

    rdy_lvl = 1'b0;
    issue(2'b01, 3'b110, 7'h00, 32'd1, 32'hFFFF_FFFF);
    repeat (3) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_result", result, 1);
    end
    @(posedge clk); #1 rdy_lvl = 1'b1;
    drain();

`ifdef ALU_SEQ_MDEXT_EN
    issue(2'b10, 3'b100, 7'h01, 32'd100, 32'd7);
    chk("busy_calc", busy, 1);
    issue(2'b10, 3'b100, 7'h01, 32'd100, 32'd0);
    issue(2'b10, 3'b110, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(2'b10, 3'b001, 7'h01, 32'hFFFF_FFF0, 32'h7000_0003);
    drain();
    issue(2'b10, 3'b000, 7'h01, 32'd123, 32'd456);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
`else
    rdy_lvl = 1'b0;
    issue(2'b00, 3'b000, 7'h00, 32'd9, 32'd9);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
`endif
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_result", result, 0);
    sbq.delete();
    head_seen = 0;
    @(posedge clk); #1 rst_n = 1'b1; rdy_lvl = 1'b1;
    issue(2'b00, 3'b000, 7'h00, 32'd2, 32'd3);
    drain();

    rand_rdy = 1;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h01;
        default: f7 = 7'($urandom_range(0, 127));
      endcase
      issue(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), f7, pick_operand(), pick_operand());
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    rand_rdy = 0;
    rdy_lvl = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq_unit.md
ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the operand/result width (legal: 32, 64).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  request valid.
REQ-005 SHALL have port in_ready  output  1  unit can accept a request this cycle.
REQ-006 SHALL have port alu_op  input  2  class: 00 load/store/AUIPC add, 01 branch, 10 R-type, 11 I-type.
REQ-007 SHALL have port funct7  input  7  instruction bits 31:25.
REQ-008 SHALL have port funct3  input  3  instruction bits 14:12.
REQ-009 SHALL have ports op_a, op_b  input  XLEN  operands (op_b carries the immediate for I-type).
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result  output  XLEN  computed value.
REQ-013 SHALL have port illegal  output  1  qualifies out_valid; the decoded encoding is unsupported.
REQ-014 SHALL have port busy  output  1  high in CALC.

Function
REQ-015 SHALL accept a request on the cycle in_valid && in_ready is true; inputs are captured, not held by the producer.
REQ-016 SHALL implement FSM IDLE, CALC, DONE; IDLE->DONE for single-cycle ops, IDLE->CALC for iterative ops, CALC->DONE after the last iteration, DONE->IDLE on out_ready unless a new request is accepted that cycle.
REQ-017 SHALL drive in_ready = (state==IDLE) || (state==DONE && out_ready), allowing back-to-back single-cycle ops at full throughput.
REQ-018 SHALL hold result and illegal stable while out_valid && !out_ready.
REQ-019 SHALL, for alu_op 00, produce op_a+op_b, independent of funct3/funct7, with 1-cycle latency.
REQ-020 SHALL, for alu_op 10 with funct7 0000000/0100000, implement ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND by funct3; funct7=0100000 is legal only with funct3 000 or 101.
REQ-021 SHALL, for alu_op 11, implement ADDI, SLTI, SLTIU, XORI, ORI, ANDI ignoring funct7; SLLI requires funct7=0000000; SRLI/SRAI are selected by funct7 0000000/0100000.
REQ-022 SHALL use only the low log2(XLEN) bits of op_b as shift amount.
REQ-023 SHALL, for alu_op 01, set result = {XLEN-1 zeros, taken} for BEQ, BNE, BLT, BGE, BLTU, BGEU (funct3 000, 001, 100, 101, 110, 111).
REQ-024 SHALL flag every other encoding as illegal: result=0, illegal=1, 1-cycle latency.
REQ-025 SHALL wrap all add/sub results modulo 2^XLEN, without flags.

Reset
REQ-026 SHALL, while rst_n=0, force state=IDLE, out_valid=0, in_ready=0, busy=0, illegal=0, result=0, iteration counter=0.
REQ-027 SHALL drive in_ready=1 from the first clock edge after rst_n deasserts.
REQ-028 SHALL abort any in-flight CALC operation on reset; no result is produced for it.

Configuration
REQ-029 SHALL compile the M extension only when ALU_SEQ_MDEXT_EN is defined.
REQ-030 SHALL, with the macro defined, decode alu_op 10 with funct7=0000001 as MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU by funct3.
REQ-031 SHALL compute multiply/divide iteratively, one bit per cycle: out_valid asserts exactly XLEN+1 cycles after acceptance.
REQ-032 SHALL complete divide-by-zero in 1 cycle: DIV/DIVU -> all ones; REM/REMU -> op_a.
REQ-033 SHALL complete signed overflow (op_a=most negative, op_b=-1) in 1 cycle: DIV -> op_a; REM -> 0.
REQ-034 SHALL, without the macro, treat funct7=0000001 as illegal; busy is then tied to 0 and CALC is unreachable.

Structure
REQ-035 SHALL place alu_op class constants, the alu_fn_t operation enum, and the FSM state_t in package alu_seq_pkg.
REQ-036 SHALL place the iterative shift-add multiplier / restoring divider in sub-module alu_muldiv_iter (start/done handshake), instantiated only under ALU_SEQ_MDEXT_EN.

Verification
REQ-037 SHALL cover: alu_op=10, f3=000, f7=0100000, a=5, b=7 -> after 1 cycle result=0xFFFFFFFE, illegal=0.
REQ-038 SHALL cover: alu_op=11, f3=101, f7=0100000, a=0x80000000, b=0x24 -> result=0xF8000000 (shamt 4).
REQ-039 SHALL cover: alu_op=01, f3=110, a=1, b=0xFFFFFFFF -> result=1; then out_ready held 0 for 3 cycles -> result stable, in_ready=0.
REQ-040 SHALL cover, with the macro defined: DIV a=100, b=7 -> result=14 at cycle 33; DIV by 0 -> 0xFFFFFFFF at cycle 1; REM 0x80000000 % -1 -> 0.
REQ-041 SHALL cover: alu_op=10, f7=0000001 with the macro undefined -> illegal=1, result=0; alu_op=10, f3=001, f7=0100000 -> illegal=1.
REQ-042 SHALL cover: rst_n pulsed low at cycle 10 of a MUL -> out_valid=0, busy=0, next ADD 2+3 -> result=5.
